// File: rtl/heap_array_manager.sv
// Heap array sequencer: allocates/frees array slots, tracks array lengths and
// runs the pipelined arrayIndex search against a 1-cycle-latency heap read port.
module heap_array_manager #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NArea              = 3,
    parameter int unsigned NArrays            = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd,
    input  logic [MemoryElementWidth-1:0] cmd_array,
    input  logic [MemoryElementWidth-1:0] cmd_index,
    input  logic [MemoryElementWidth-1:0] cmd_value,
    output logic                          rsp_valid,
    output logic [MemoryElementWidth-1:0] rsp_data,
    output logic                          rsp_error,
    output logic                          heap_rd_en,
    output logic [MemoryElementWidth-1:0] heap_rd_addr,
    input  logic [MemoryElementWidth-1:0] heap_rd_data,
    output logic [MemoryElementWidth-1:0] allocs
);

    localparam int unsigned W  = MemoryElementWidth;
    localparam int unsigned AW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int unsigned TW = $clog2(NArrays + 1);

    localparam logic [W-1:0] NARR_W  = W'(NArrays);
    localparam logic [W-1:0] NAREA_W = W'(NArea);

    localparam logic [1:0] CMD_ALLOC  = 2'd0;
    localparam logic [1:0] CMD_FREE   = 2'd1;
    localparam logic [1:0] CMD_INDEX  = 2'd2;
    localparam logic [1:0] CMD_SETLEN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                       r_state,   w_state;
    logic [W-1:0]                 r_allocs,  w_allocs;
    logic [TW-1:0]                r_top,     w_top;
    logic [NArrays-1:0][AW-1:0]   r_stack,   w_stack;
    logic [NArrays-1:0]           r_in_use,  w_in_use;
    logic [NArrays-1:0][W-1:0]    r_size,    w_size;
    logic [W-1:0]                 r_value,   w_value;
    logic [W-1:0]                 r_base,    w_base;
    logic [W-1:0]                 r_len,     w_len;
    logic [W-1:0]                 r_rd_idx,  w_rd_idx;
    logic                         r_cmp_vld, w_cmp_vld;
    logic [W-1:0]                 r_cmp_pos, w_cmp_pos;
    logic [W-1:0]                 r_result,  w_result;
    logic                         r_cmd_ready, w_cmd_ready;
    logic                         r_rsp_valid, w_rsp_valid;
    logic [W-1:0]                 r_rsp_data,  w_rsp_data;
    logic                         r_rsp_error, w_rsp_error;
    logic                         r_rd_en,     w_rd_en;
    logic [W-1:0]                 r_rd_addr,   w_rd_addr;

    logic                         w_arr_ok;
    logic [AW-1:0]                w_idx;
    logic                         w_used;
    logic [AW-1:0]                w_pop;
    logic [AW-1:0]                w_alloc_idx;
    logic                         w_alloc_ok;
    logic                         w_match;

    // Next-state and next-output logic for the whole sequencer
    always_comb begin
        w_state     = r_state;
        w_allocs    = r_allocs;
        w_top       = r_top;
        w_stack     = r_stack;
        w_in_use    = r_in_use;
        w_size      = r_size;
        w_value     = r_value;
        w_base      = r_base;
        w_len       = r_len;
        w_rd_idx    = r_rd_idx;
        w_cmp_vld   = 1'b0;
        w_cmp_pos   = r_cmp_pos;
        w_result    = r_result;
        w_rsp_valid = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_rsp_error = r_rsp_error;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_rd_addr;
        w_alloc_idx = '0;
        w_alloc_ok  = 1'b0;

        w_arr_ok = (cmd_array < NARR_W);
        w_idx    = cmd_array[AW-1:0];
        w_used   = w_arr_ok && r_in_use[w_idx];
        w_pop    = AW'(r_top - TW'(1));
        w_match  = (heap_rd_data == r_value);

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state     = ST_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_error = 1'b0;
                    case (cmd)
                        CMD_ALLOC: begin
                            // Recycled slots (LIFO) take priority over fresh ones
                            if (r_top != '0) begin
                                w_top       = r_top - TW'(1);
                                w_alloc_idx = r_stack[w_pop];
                                w_alloc_ok  = 1'b1;
                            end else if (r_allocs < NARR_W) begin
                                w_alloc_idx = r_allocs[AW-1:0];
                                w_allocs    = r_allocs + W'(1);
                                w_alloc_ok  = 1'b1;
                            end else begin
                                w_rsp_error = 1'b1;
                            end
                            if (w_alloc_ok) begin
                                w_rsp_data            = W'(w_alloc_idx);
                                w_in_use[w_alloc_idx] = 1'b1;
                                w_size[w_alloc_idx]   = '0;
                            end
                        end
                        CMD_FREE: begin
                            if ((cmd_array >= r_allocs) || !w_used) begin
                                w_rsp_error = 1'b1;
                            end else begin
                                w_stack[AW'(r_top)] = w_idx;
                                w_top               = r_top + TW'(1);
                                w_in_use[w_idx]     = 1'b0;
                            end
                        end
                        CMD_SETLEN: begin
                            if (!w_used || (cmd_index >= NAREA_W)) begin
                                w_rsp_error = 1'b1;
                            end else if (r_size[w_idx] < (cmd_index + W'(1))) begin
                                w_size[w_idx] = cmd_index + W'(1);
                            end
                        end
                        default: begin
                            if (!w_used) begin
                                w_rsp_error = 1'b1;
                            end else if (r_size[w_idx] != '0) begin
                                // Non-empty array: launch the scan, keep the previous response
                                w_state     = ST_SCAN;
                                w_rsp_valid = 1'b0;
                                w_rsp_data  = r_rsp_data;
                                w_rsp_error = r_rsp_error;
                                w_value     = cmd_value;
                                w_base      = W'(cmd_array * NArea);
                                w_len       = r_size[w_idx];
                                w_result    = '0;
                                w_rd_en     = 1'b1;
                                w_rd_addr   = W'(cmd_array * NArea);
                                w_rd_idx    = W'(1);
                                w_cmp_pos   = '0;
                            end
                        end
                    endcase
                end
            end
            ST_SCAN: begin
                if (r_rd_idx < r_len) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_base + r_rd_idx;
                    w_rd_idx  = r_rd_idx + W'(1);
                end
                // r_cmp_pos is the 1-based position of the word returning next cycle
                w_cmp_vld = r_rd_en;
                w_cmp_pos = r_rd_idx;
                if (r_cmp_vld) begin
                    if (w_match) begin
                        w_result = r_cmp_pos;
                    end
                    if (r_cmp_pos == r_len) begin
                        w_state     = ST_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_error = 1'b0;
                        w_rsp_data  = w_match ? r_cmp_pos : r_result;
                    end
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_cmd_ready = (w_state == ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_allocs    <= '0;
            r_top       <= '0;
            r_stack     <= '0;
            r_in_use    <= '0;
            r_size      <= '0;
            r_value     <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_rd_idx    <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_pos   <= '0;
            r_result    <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            r_state     <= w_state;
            r_allocs    <= w_allocs;
            r_top       <= w_top;
            r_stack     <= w_stack;
            r_in_use    <= w_in_use;
            r_size      <= w_size;
            r_value     <= w_value;
            r_base      <= w_base;
            r_len       <= w_len;
            r_rd_idx    <= w_rd_idx;
            r_cmp_vld   <= w_cmp_vld;
            r_cmp_pos   <= w_cmp_pos;
            r_result    <= w_result;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_error <= w_rsp_error;
            r_rd_en     <= w_rd_en;
            r_rd_addr   <= w_rd_addr;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_error    = r_rsp_error;
    assign heap_rd_en   = r_rd_en;
    assign heap_rd_addr = r_rd_addr;
    assign allocs       = r_allocs;

endmodule

// File: tb/tb_heap_array_manager.sv
// Self-checking bench for heap_array_manager: directed plan plus random
// commands checked against a behavioural slot/length/search model.
module tb_heap_array_manager;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd = 2'd0;
    logic [11:0] cmd_array = '0;
    logic [11:0] cmd_index = '0;
    logic [11:0] cmd_value = '0;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        rsp_error;
    logic        heap_rd_en;
    logic [11:0] heap_rd_addr;
    logic [11:0] heap_rd_data = '0;
    logic [11:0] allocs;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] mem [0:4095];
    logic [11:0] rd_q[$];

    int m_allocs;
    int m_used [4];
    int m_size [4];
    int m_free[$];

    heap_array_manager dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .cmd_array   (cmd_array),
        .cmd_index   (cmd_index),
        .cmd_value   (cmd_value),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .heap_rd_en  (heap_rd_en),
        .heap_rd_addr(heap_rd_addr),
        .heap_rd_data(heap_rd_data),
        .allocs      (allocs)
    );

    always #5 clock = ~clock;

    // Heap model: synchronous read, 1-cycle latency; logs every read address
    always @(posedge clock) begin
        if (heap_rd_en) begin
            heap_rd_data <= mem[heap_rd_addr];
            rd_q.push_back(heap_rd_addr);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_allocs = 0;
        m_free.delete();
        for (int i = 0; i < 4; i++) begin
            m_used[i] = 0;
            m_size[i] = 0;
        end
    endfunction

    function automatic void model_exec(input int c, input int a, input int idx, input int v,
                                       output int d, output int e, output int lat, output int nr);
        d = 0; e = 0; lat = 1; nr = 0;
        case (c)
            0: begin
                if (m_free.size() > 0) begin
                    d = m_free.pop_back();
                    m_used[d] = 1; m_size[d] = 0;
                end else if (m_allocs < 4) begin
                    d = m_allocs;
                    m_allocs++;
                    m_used[d] = 1; m_size[d] = 0;
                end else e = 1;
            end
            1: begin
                if (a >= m_allocs || m_used[a] == 0) e = 1;
                else begin
                    m_free.push_back(a);
                    m_used[a] = 0;
                end
            end
            2: begin
                if (a >= 4 || m_used[a] == 0) e = 1;
                else begin
                    nr = m_size[a];
                    if (nr > 0) lat = nr + 2;
                    for (int i = 0; i < nr; i++)
                        if (int'(mem[a*3+i]) == v) d = i + 1;
                end
            end
            default: begin
                if (a >= 4 || m_used[a] == 0 || idx >= 3) e = 1;
                else if (m_size[a] < idx + 1) m_size[a] = idx + 1;
            end
        endcase
    endfunction

    // Issue one command, wait for its response, and check everything about it
    task automatic run(input int c, input int a, input int idx, input int v);
        int ed, ee, el, enr, lat;
        model_exec(c, a, idx, v, ed, ee, el, enr);
        rd_q.delete();
        cmd = 2'(c); cmd_array = 12'(a); cmd_index = 12'(idx); cmd_value = 12'(v);
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check($sformatf("lat c%0d a%0d", c, a), lat, el);
        check($sformatf("data c%0d a%0d", c, a), int'(rsp_data), ed);
        check($sformatf("err c%0d a%0d", c, a), int'(rsp_error), ee);
        check("allocs", int'(allocs), m_allocs);
        @(posedge clock); #1;
        check("pulse_len", int'(rsp_valid), 0);
        check("ready_back", int'(cmd_ready), 1);
        check("held_data", int'(rsp_data), ed);
        check("n_reads", rd_q.size(), enr);
        for (int j = 0; j < rd_q.size() && j < enr; j++)
            check($sformatf("rd_addr%0d", j), int'(rd_q[j]), a * 3 + j);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #12;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_valid", int'(rsp_valid), 0);
        check("rst_data", int'(rsp_data), 0);
        check("rst_err", int'(rsp_error), 0);
        check("rst_rden", int'(heap_rd_en), 0);
        check("rst_rdaddr", int'(heap_rd_addr), 0);
        check("rst_allocs", int'(allocs), 0);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        model_reset();
        @(posedge clock); #1;
        apply_reset();

        for (int i = 0; i < 5; i++) run(0, 0, 0, 0);
        run(1, 2, 0, 0); run(1, 0, 0, 0);
        run(0, 0, 0, 0); run(0, 0, 0, 0);
        run(1, 0, 0, 0); run(1, 0, 0, 0);
        run(1, 7, 0, 0);
        run(0, 0, 0, 0);

        mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30;
        run(3, 0, 0, 0); run(3, 0, 1, 0); run(3, 0, 2, 0);
        run(2, 0, 0, 20);
        mem[0] = 12'd20; mem[1] = 12'd20; mem[2] = 12'd5;
        run(2, 0, 0, 20);
        run(2, 0, 0, 99);
        run(2, 1, 0, 10);
        run(3, 1, 3, 0);
        mem[3] = 12'd7; mem[4] = 12'd7;
        run(3, 1, 1, 0); run(3, 1, 0, 0);
        run(2, 1, 0, 7);

        // Reset in the middle of a scan (second read cycle)
        cmd = 2'd2; cmd_array = 12'd0; cmd_value = 12'd20; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        check("scan_rd2", int'(heap_rd_en), 1);
        reset = 1'b1;
        model_reset();
        seen = 0;
        repeat (3) begin
            @(posedge clock); #1;
            seen |= int'(rsp_valid);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        seen |= int'(rsp_valid);
        check("abort_no_rsp", seen, 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_allocs", int'(allocs), 0);
        run(0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int c, a;
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, 11)] = 12'($urandom_range(0, 7));
            c = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 5));
            run(c, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
